// File: rtl/rsa_mont_exp.sv
// ---------------------------------------------------------------------------
// rsa_mont_exp -- modular exponentiation sequencer (Montgomery domain)
//
// Computes o_out = i_base ^ i_exponent mod i_modulus.
// Every multiplication is handed to an external Montgomery multiplier, which
// returns a*b*R^-1 mod N with R = 2^MOD_WIDTH. At most one request is in
// flight at any time.
//
// Sequence: convert the base into the Montgomery domain, convert 1 into the
// Montgomery domain, run left-to-right square-and-multiply over the exponent
// bits (MSB first), then convert the result back out.
//
// Optional feature: define RSA_MONT_EXP_SKIP_ZERO_EN to skip the leading zero
// exponent bits. Squaring the Montgomery form of 1 gives the same value back,
// so the result is identical in both builds; the skip only saves requests.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   i_valid/i_ready     job handshake; i_base, i_exponent, i_modulus (odd,
//                       > 1) and i_r2 (R^2 mod N) are latched on acceptance
//   o_valid/o_ready     result handshake; o_out holds base^exp mod N
//   m_valid/m_ready     multiplier request; m_a, m_b, m_modulus
//   r_valid/r_ready     multiplier response; r_out may lie in [N, 2N)
// ---------------------------------------------------------------------------
module rsa_mont_exp #(
  parameter int MOD_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_base,
  input  logic [MOD_WIDTH-1:0] i_exponent,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  input  logic [MOD_WIDTH-1:0] i_r2,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [MOD_WIDTH-1:0] m_a,
  output logic [MOD_WIDTH-1:0] m_b,
  output logic [MOD_WIDTH-1:0] m_modulus,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [MOD_WIDTH-1:0] r_out
);

  localparam int CW = (MOD_WIDTH > 1) ? $clog2(MOD_WIDTH) : 1;
  localparam logic [CW-1:0] TOP_BIT = CW'(MOD_WIDTH - 1);
  localparam logic [MOD_WIDTH-1:0] ONE = MOD_WIDTH'(1);

  // Each multiplier operation has an ISSUE phase (request offered) and a
  // WAIT phase (response accepted), so m_valid and r_ready are exclusive.
  typedef enum logic [3:0] {
    S_IDLE,
    S_CB_ISSUE, S_CB_WAIT,   // base * R^2 -> xb
    S_C1_ISSUE, S_C1_WAIT,   // 1 * R^2    -> acc
    S_SQ_ISSUE, S_SQ_WAIT,   // acc * acc  -> acc
    S_MU_ISSUE, S_MU_WAIT,   // acc * xb   -> acc
    S_CO_ISSUE, S_CO_WAIT,   // acc * 1    -> final result
    S_DONE
  } state_e;

  state_e                 state_q,   state_d;
  logic [MOD_WIDTH-1:0]   base_q,    base_d;
  logic [MOD_WIDTH-1:0]   exp_q,     exp_d;
  logic [MOD_WIDTH-1:0]   mod_q,     mod_d;
  logic [MOD_WIDTH-1:0]   r2_q,      r2_d;
  logic [MOD_WIDTH-1:0]   xb_q,      xb_d;
  logic [MOD_WIDTH-1:0]   acc_q,     acc_d;
  logic [MOD_WIDTH-1:0]   out_q,     out_d;
  logic [CW-1:0]          cnt_q,     cnt_d;
  logic                   m_valid_q, m_valid_d;
  logic [MOD_WIDTH-1:0]   m_a_q,     m_a_d;
  logic [MOD_WIDTH-1:0]   m_b_q,     m_b_d;

  // Single conditional subtract: the multiplier guarantees r_out < 2N, so
  // the difference (when no borrow) is already below N. The extra bit is the
  // borrow, i.e. r_out < N.
  logic [MOD_WIDTH:0]     r_diff;
  logic [MOD_WIDTH-1:0]   r_red;

  assign r_diff = {1'b0, r_out} - {1'b0, mod_q};
  assign r_red  = r_diff[MOD_WIDTH] ? r_out : r_diff[MOD_WIDTH-1:0];

  assign i_ready   = (state_q == S_IDLE);
  assign o_valid   = (state_q == S_DONE);
  assign o_out     = out_q;
  assign m_valid   = m_valid_q;
  assign m_a       = m_a_q;
  assign m_b       = m_b_q;
  assign m_modulus = mod_q;
  assign r_ready   = (state_q == S_CB_WAIT) || (state_q == S_C1_WAIT) ||
                     (state_q == S_SQ_WAIT) || (state_q == S_MU_WAIT) ||
                     (state_q == S_CO_WAIT);

`ifdef RSA_MONT_EXP_SKIP_ZERO_EN
  // Index of the most significant set exponent bit (0 when exponent is 0,
  // which is handled separately).
  logic [CW-1:0] first_one;
  always_comb begin
    first_one = '0;
    for (int i = 0; i < MOD_WIDTH; i++) begin
      if (exp_q[i]) first_one = CW'(i);
    end
  end
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d = state_q;
    base_d  = base_q;
    exp_d   = exp_q;
    mod_d   = mod_q;
    r2_d    = r2_q;
    xb_d    = xb_q;
    acc_d   = acc_q;
    out_d   = out_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          base_d  = i_base;
          exp_d   = i_exponent;
          mod_d   = i_modulus;
          r2_d    = i_r2;
          state_d = S_CB_ISSUE;
        end
      end
      S_CB_ISSUE: if (m_ready) state_d = S_CB_WAIT;
      S_C1_ISSUE: if (m_ready) state_d = S_C1_WAIT;
      S_SQ_ISSUE: if (m_ready) state_d = S_SQ_WAIT;
      S_MU_ISSUE: if (m_ready) state_d = S_MU_WAIT;
      S_CO_ISSUE: if (m_ready) state_d = S_CO_WAIT;
      S_CB_WAIT: begin
        if (r_valid) begin
          xb_d    = r_red;
          state_d = S_C1_ISSUE;
        end
      end
      S_C1_WAIT: begin
        if (r_valid) begin
          acc_d = r_red;
`ifdef RSA_MONT_EXP_SKIP_ZERO_EN
          if (exp_q == '0) begin
            state_d = S_CO_ISSUE;
          end else begin
            cnt_d   = first_one;
            state_d = S_SQ_ISSUE;
          end
`else
          cnt_d   = TOP_BIT;
          state_d = S_SQ_ISSUE;
`endif
        end
      end
      S_SQ_WAIT: begin
        if (r_valid) begin
          acc_d = r_red;
          if (exp_q[cnt_q]) begin
            state_d = S_MU_ISSUE;
          end else if (cnt_q == '0) begin
            state_d = S_CO_ISSUE;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            state_d = S_SQ_ISSUE;
          end
        end
      end
      S_MU_WAIT: begin
        if (r_valid) begin
          acc_d = r_red;
          if (cnt_q == '0) begin
            state_d = S_CO_ISSUE;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            state_d = S_SQ_ISSUE;
          end
        end
      end
      S_CO_WAIT: begin
        if (r_valid) begin
          out_d   = r_red;
          state_d = S_DONE;
        end
      end
      S_DONE: if (o_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Operands are registered from the next-state view, so they are valid in
    // the same cycle m_valid rises and stay put while the ISSUE state waits
    // (all sources are unchanged while waiting for m_ready).
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;
    m_valid_d = 1'b1;
    case (state_d)
      S_CB_ISSUE: begin m_a_d = base_d; m_b_d = r2_d;  end
      S_C1_ISSUE: begin m_a_d = ONE;    m_b_d = r2_d;  end
      S_SQ_ISSUE: begin m_a_d = acc_d;  m_b_d = acc_d; end
      S_MU_ISSUE: begin m_a_d = acc_d;  m_b_d = xb_d;  end
      S_CO_ISSUE: begin m_a_d = acc_d;  m_b_d = ONE;   end
      default:    m_valid_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the wide datapath registers are reset as well, so operand
      // outputs and a late multiplier response never expose stale job data.
      state_q   <= S_IDLE;
      base_q    <= '0;
      exp_q     <= '0;
      mod_q     <= '0;
      r2_q      <= '0;
      xb_q      <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      exp_q     <= exp_d;
      mod_q     <= mod_d;
      r2_q      <= r2_d;
      xb_q      <= xb_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
    end
  end

endmodule

// File: tb/tb_rsa_mont_exp.sv
// ---------------------------------------------------------------------------
// tb_rsa_mont_exp -- self-checking bench for rsa_mont_exp at MOD_WIDTH = 8.
//
// A behavioural Montgomery multiplier answers every request one cycle after
// acceptance. Expected exponentiation results come from plain repeated
// modular multiplication, are pushed to a queue when a job is launched and
// popped when the DUT presents its result.
//
// Timing: the bench drives job/result signals on the falling edge, the
// multiplier model updates 2 time units after it, and a protocol monitor
// samples 1 time unit after it, so nothing races the rising edge.
// ---------------------------------------------------------------------------
module tb_rsa_mont_exp;

  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [MW-1:0] i_base = '0;
  logic [MW-1:0] i_exponent = '0;
  logic [MW-1:0] i_modulus = '0;
  logic [MW-1:0] i_r2 = '0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [MW-1:0] o_out;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [MW-1:0] m_a;
  logic [MW-1:0] m_b;
  logic [MW-1:0] m_modulus;
  logic          r_valid = 1'b0;
  logic          r_ready;
  logic [MW-1:0] r_out = '0;

  rsa_mont_exp #(.MOD_WIDTH(MW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_base(i_base), .i_exponent(i_exponent),
    .i_modulus(i_modulus), .i_r2(i_r2),
    .o_valid(o_valid), .o_ready(o_ready), .o_out(o_out),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_a(m_a), .m_b(m_b), .m_modulus(m_modulus),
    .r_valid(r_valid), .r_ready(r_ready), .r_out(r_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int unsigned exp_q[$];

  // Multiplier model controls / statistics.
  bit stall   = 1'b0;   // hold m_ready low
  bit unred   = 1'b0;   // return r_out + N whenever it fits
  int req_count = 0;
  int unred_hits = 0;
  int proto_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int unsigned golden(input int unsigned b,
                                         input int unsigned e,
                                         input int unsigned n);
    int unsigned r;
    r = 1 % n;
    for (int i = 0; i < int'(e); i++) r = (r * b) % n;
    return r;
  endfunction

  function automatic int unsigned r_inv(input int unsigned n);
    for (int unsigned x = 1; x < n; x++)
      if (((256 * x) % n) == 1) return x;
    return 0;
  endfunction

  // ---------------- behavioural Montgomery multiplier ----------------
  initial begin : mult_model
    bit lat_mv, lat_mr, lat_rv, lat_rr, lat_rst;
    int unsigned lat_a, lat_b, lat_n, res;
    int flush;
    lat_mv = 0; lat_mr = 0; lat_rv = 0; lat_rr = 0; lat_rst = 1;
    lat_a = 0; lat_b = 0; lat_n = 1; flush = 0;
    forever begin
      @(negedge clk);
      #2;
      if (lat_rst) begin
        // Response arriving after a reset: kept up a few cycles, must be ignored.
        r_valid = 1'b1;
        r_out   = 8'hA5;
        flush   = 3;
      end else if (flush > 0) begin
        flush--;
        if (flush == 0) r_valid = 1'b0;
      end else begin
        if (lat_rv && lat_rr) r_valid = 1'b0;
        if (lat_mv && lat_mr) begin
          req_count++;
          res = (((lat_a * lat_b) % lat_n) * r_inv(lat_n)) % lat_n;
          if (unred && (res + lat_n <= 255)) begin
            res = res + lat_n;
            unred_hits++;
          end
          r_valid = 1'b1;
          r_out   = res[MW-1:0];
        end
      end
      m_ready = !stall;
      lat_mv = m_valid; lat_mr = m_ready; lat_rv = r_valid; lat_rr = r_ready;
      lat_a = m_a; lat_b = m_b; lat_n = (m_modulus == 0) ? 1 : m_modulus;
      lat_rst = rst;
    end
  end

  // ---------------- request-channel protocol monitor ----------------
  initial begin : proto_mon
    bit prev_mv, prev_rst;
    logic [MW-1:0] prev_a, prev_b, prev_n;
    prev_mv = 0; prev_rst = 1; prev_a = 0; prev_b = 0; prev_n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (m_valid && r_ready) proto_err++;
      if (!prev_rst && prev_mv) begin
        if (!m_ready && (!m_valid || m_a !== prev_a || m_b !== prev_b ||
                         m_modulus !== prev_n)) proto_err++;
        if (m_ready && m_valid) proto_err++;
      end
      prev_mv = m_valid; prev_a = m_a; prev_b = m_b; prev_n = m_modulus;
      prev_rst = rst;
    end
  end

  // ---------------- job helpers ----------------
  task automatic start_job(input int unsigned b, input int unsigned e,
                           input int unsigned n);
    int k;
    i_base     = b[MW-1:0];
    i_exponent = e[MW-1:0];
    i_modulus  = n[MW-1:0];
    i_r2       = 8'((256 * 256) % n);
    i_valid    = 1'b1;
    k = 0;
    while (!i_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("accept_timeout", 0, 1);
    @(negedge clk);
    i_valid = 1'b0;
    exp_q.push_back(golden(b, e, n));
  endtask

  task automatic finish_job(input string tag, input bit hold5);
    int k;
    int unsigned expv;
    int rc;
    logic [MW-1:0] held;
    k = 0;
    while (!o_valid && k < 3000) begin
      @(negedge clk);
      k++;
    end
    expv = exp_q.pop_front();
    if (k >= 3000) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_o_out"}, o_out, expv);
    if (hold5) begin
      held       = o_out;
      rc         = req_count;
      i_base     = 8'd9;
      i_exponent = 8'd9;
      i_modulus  = 8'd187;
      i_r2       = 8'd86;
      i_valid    = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check({tag, "_hold_o_valid"}, o_valid, 1);
        check({tag, "_hold_o_out"}, o_out, held);
        check({tag, "_hold_i_ready"}, i_ready, 0);
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      @(negedge clk);
      o_ready = 1'b0;
      check({tag, "_idle_i_ready"}, i_ready, 1);
      repeat (5) @(negedge clk);
      check({tag, "_no_new_job"}, req_count, rc);
      check({tag, "_no_m_valid"}, m_valid, 0);
    end else begin
      o_ready = 1'b1;
      @(negedge clk);
      o_ready = 1'b0;
      check({tag, "_idle_i_ready"}, i_ready, 1);
      check({tag, "_idle_o_valid"}, o_valid, 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int rc, k;
    logic [MW-1:0] a0, b0;
    int exp_reqs_a, exp_reqs_zero;
`ifdef RSA_MONT_EXP_SKIP_ZERO_EN
    exp_reqs_a = 8;  exp_reqs_zero = 3;
`else
    exp_reqs_a = 13; exp_reqs_zero = 11;
`endif

    repeat (2) @(negedge clk);
    check("rst_i_ready", i_ready, 1);
    check("rst_o_valid", o_valid, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_r_ready", r_ready, 0);
    check("rst_o_out", o_out, 0);
    check("rst_m_a", m_a, 0);
    check("rst_m_b", m_b, 0);
    check("rst_m_modulus", m_modulus, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);   // let the post-reset flush drain

    // 3^5 mod 187
    rc = req_count;
    start_job(3, 5, 187);
    finish_job("exp5", 1'b0);
    check("exp5_reqs", req_count - rc, exp_reqs_a);

    // exponent 0
    rc = req_count;
    start_job(160, 0, 187);
    finish_job("exp0", 1'b0);
    check("exp0_reqs", req_count - rc, exp_reqs_zero);

    // m_ready held low on the first request
    stall = 1'b1;
    repeat (2) @(negedge clk);
    start_job(7, 200, 187);
    a0 = m_a;
    b0 = m_b;
    check("stall_first_a", a0, 7);
    check("stall_first_b", b0, 86);
    for (int i = 0; i < 10; i++) begin
      check("stall_m_valid", m_valid, 1);
      check("stall_m_a", m_a, a0);
      check("stall_m_b", m_b, b0);
      @(negedge clk);
    end
    check("stall_m_modulus", m_modulus, 187);
    stall = 1'b0;
    finish_job("stall", 1'b0);

    // unreduced multiplier results
    unred = 1'b1;
    start_job(3, 5, 187);
    finish_job("unred", 1'b0);
    unred = 1'b0;
    check("unred_exercised", (unred_hits > 0), 1);

    // reset during the first SQUARE
    rc = req_count;
    start_job(3, 5, 187);
    k = 0;
    while (req_count < rc + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("rst_mid_timeout", 0, 1);
    void'(exp_q.pop_back());   // aborted job never completes
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_i_ready", i_ready, 1);
    check("rst_mid_m_valid", m_valid, 0);
    check("rst_mid_r_ready", r_ready, 0);
    check("rst_mid_o_valid", o_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_late_r_ready", r_ready, 0);
      check("rst_late_m_valid", m_valid, 0);
    end
    repeat (2) @(negedge clk);
    start_job(12, 255, 187);
    finish_job("after_rst", 1'b0);

    // o_ready held low in DONE, i_valid high meanwhile
    start_job(100, 77, 251);
    finish_job("ohold", 1'b1);

    // assorted operands and moduli
    start_job(2, 128, 253);  finish_job("m253", 1'b0);
    start_job(186, 3, 187);  finish_job("nm1", 1'b0);
    start_job(0, 9, 187);    finish_job("base0", 1'b0);
    start_job(254, 255, 255); finish_job("m255", 1'b0);
    start_job(5, 1, 3);      finish_job("m3", 1'b0);
    for (int i = 0; i < 4; i++) begin
      int unsigned n, b, e;
      n = 2 * $urandom_range(1, 127) + 1;
      b = $urandom_range(0, n - 1);
      e = $urandom_range(0, 255);
      start_job(b, e, n);
      finish_job("rand", 1'b0);
    end

    check("protocol_errors", proto_err, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
